// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: groups the serial input and the frame outputs of
// uart_rx_frame into one bundle.
// Handshake: frameValid is a one-cycle strobe. setpointCh1/setpointCh2 are
// valid from the cycle frameValid is high and hold until the next accepted
// frame. frameError is a one-cycle strobe that never coincides with
// frameValid. There is no back-pressure: the receiver has no ready input.
// dbg_state mirrors the bit FSM state so checkers can observe it.
interface uart_rx_frame_if;
  logic        uart_rx;
  logic [14:0] setpointCh1;
  logic [14:0] setpointCh2;
  logic        frameValid;
  logic        frameError;
  logic [2:0]  dbg_state;

  modport master (
    output uart_rx,
    input  setpointCh1, setpointCh2, frameValid, frameError, dbg_state
  );

  modport slave (
    input  uart_rx,
    output setpointCh1, setpointCh2, frameValid, frameError, dbg_state
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver plus 5-byte frame parser
// (ch1 hi, ch1 lo, ch2 hi, ch2 lo, 0x0A) producing two 15-bit words.
// Optional feature macro: UART_RX_TIMEOUT_EN enables an inter-byte gap
// timeout that abandons a stalled partial frame.
// dbg_state encoding: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 WAIT_HIGH.
module uart_rx_frame #(
  parameter int DELAY_FRAMES = 234,
  parameter int TIMEOUT_BITS = 16
) (
  input logic            clk,
  input logic            rst,
  uart_rx_frame_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(DELAY_FRAMES / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(DELAY_FRAMES - 1);

  // Synchronizer, both stages idle high
  logic sync1_q;
  logic rx_s_q;

  // Bit FSM
  state_t      state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_strobe;
  logic        stop_err;

  // Frame parser
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        resync_q, resync_d;
  logic [6:0]  hi1_q, hi1_d, hi2_q, hi2_d;
  logic [7:0]  lo1_q, lo1_d, lo2_q, lo2_d;
  logic [14:0] ch1_q, ch1_d, ch2_q, ch2_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  // Two-stage synchronizer for the asynchronous pin
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Bit FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Bit FSM next state: half-bit wait to centre on the start bit, then full bits
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_strobe = 1'b0;
    stop_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;          // too short to be a start bit
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            byte_strobe = 1'b1;
            state_d     = S_IDLE;
          end else begin
            stop_err = 1'b1;
            state_d  = S_WAIT_HIGH;    // a held-low line must not retrigger
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        bit_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [31:0] GAP_LAST = 32'(TIMEOUT_BITS * DELAY_FRAMES - 1);
  logic [31:0] gap_q;

  assign timeout_hit = (state_q == S_IDLE) && (byte_idx_q != 3'd0) &&
                       (gap_q == GAP_LAST);

  // Gap counter: idle time between bytes of a partially received frame
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else if (state_q != S_IDLE || byte_idx_q == 3'd0 || !rx_s_q ||
                 timeout_hit) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 32'd1;
    end
  end
`else
  // Without the timeout a stalled partial frame simply waits
  assign timeout_hit = 1'b0;
`endif

  // Parser registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      resync_q   <= 1'b0;
      hi1_q      <= '0;
      lo1_q      <= '0;
      hi2_q      <= '0;
      lo2_q      <= '0;
      ch1_q      <= '0;
      ch2_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      resync_q   <= resync_d;
      hi1_q      <= hi1_d;
      lo1_q      <= lo1_d;
      hi2_q      <= hi2_d;
      lo2_q      <= lo2_d;
      ch1_q      <= ch1_d;
      ch2_q      <= ch2_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Parser next state: stage bytes, commit both words only on a good terminator
  always_comb begin
    byte_idx_d = byte_idx_q;
    resync_d   = resync_q;
    hi1_d      = hi1_q;
    lo1_d      = lo1_q;
    hi2_d      = hi2_q;
    lo2_d      = lo2_q;
    ch1_d      = ch1_q;
    ch2_d      = ch2_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (stop_err) begin
      err_d      = 1'b1;
      resync_d   = 1'b1;
      byte_idx_d = '0;
    end else if (byte_strobe) begin
      if (resync_q) begin
        if (shift_q == 8'h0A) begin
          resync_d   = 1'b0;
          byte_idx_d = '0;
        end
      end else begin
        case (byte_idx_q)
          3'd0, 3'd2: begin
            if (shift_q[7]) begin
              err_d      = 1'b1;
              resync_d   = 1'b1;
              byte_idx_d = '0;
            end else begin
              if (byte_idx_q == 3'd0) hi1_d = shift_q[6:0];
              else                    hi2_d = shift_q[6:0];
              byte_idx_d = byte_idx_q + 3'd1;
            end
          end
          3'd1: begin
            lo1_d      = shift_q;
            byte_idx_d = 3'd2;
          end
          3'd3: begin
            lo2_d      = shift_q;
            byte_idx_d = 3'd4;
          end
          default: begin
            if (shift_q == 8'h0A) begin
              ch1_d   = {hi1_q, lo1_q};
              ch2_d   = {hi2_q, lo2_q};
              valid_d = 1'b1;
            end else begin
              err_d    = 1'b1;
              resync_d = 1'b1;
            end
            byte_idx_d = '0;
          end
        endcase
      end
    end else if (timeout_hit) begin
      err_d      = 1'b1;
      resync_d   = 1'b0;
      byte_idx_d = '0;
    end
  end

  assign bus.setpointCh1 = ch1_q;
  assign bus.setpointCh2 = ch2_q;
  assign bus.frameValid  = valid_q;
  assign bus.frameError  = err_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames on the serial line, expected events
// pushed into a queue and checked by an independent monitor.
module tb_uart_rx_frame;
  localparam int DF = 234;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_frame_if bus();

  uart_rx_frame #(.DELAY_FRAMES(DF), .TIMEOUT_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stop_start_cyc = 0;

  // Scoreboard entry: {is_valid, ch1, ch2}
  logic [30:0] exp_q[$];
  logic [14:0] exp_ch1 = '0;
  logic [14:0] exp_ch2 = '0;
  logic [14:0] prev_ch1 = '0;
  logic [14:0] prev_ch2 = '0;
  logic [30:0] ent;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      prev_ch1 = bus.setpointCh1;
      prev_ch2 = bus.setpointCh2;
    end else begin
      if (bus.frameValid && bus.frameError) begin
        total++; bad++;
        $display("FAIL both_pulses: frameValid and frameError high together at cycle %0d", cyc);
      end
      if (bus.frameValid || bus.frameError) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: got valid=%0b error=%0b, required no event", bus.frameValid, bus.frameError);
        end else begin
          ent = exp_q.pop_front();
          check("event_kind", 32'(bus.frameValid), 32'(ent[30]));
          check("ch1", 32'(bus.setpointCh1), 32'(ent[29:15]));
          check("ch2", 32'(bus.setpointCh2), 32'(ent[14:0]));
          if (bus.frameValid) begin
            total++;
            if ((cyc - stop_start_cyc) < 110 || (cyc - stop_start_cyc) > 130) begin
              bad++;
              $display("FAIL valid_latency: got %0d cycles after stop bit start, required 110..130", cyc - stop_start_cyc);
            end
          end
        end
      end else if (bus.setpointCh1 !== prev_ch1 || bus.setpointCh2 !== prev_ch2) begin
        total++; bad++;
        $display("FAIL outputs_changed: got %0h/%0h, required %0h/%0h (no frameValid)", bus.setpointCh1, bus.setpointCh2, prev_ch1, prev_ch2);
      end
      prev_ch1 = bus.setpointCh1;
      prev_ch2 = bus.setpointCh2;
    end
  end

  // Driver tasks (called at a falling edge)
  task automatic drive_bit(input logic v, input int n);
    bus.uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0, DF);
    for (int i = 0; i < 8; i++) drive_bit(b[i], DF);
    stop_start_cyc = cyc;
    drive_bit(stop_v, DF);
  endtask

  task automatic send_good_frame(input logic [7:0] h1, input logic [7:0] l1,
                                 input logic [7:0] h2, input logic [7:0] l2);
    exp_ch1 = {h1[6:0], l1};
    exp_ch2 = {h2[6:0], l2};
    exp_q.push_back({1'b1, exp_ch1, exp_ch2});
    send_byte(h1, 1'b1);
    send_byte(l1, 1'b1);
    send_byte(h2, 1'b1);
    send_byte(l2, 1'b1);
    send_byte(8'h0A, 1'b1);
  endtask

  task automatic push_error();
    exp_q.push_back({1'b0, exp_ch1, exp_ch2});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_ch1", 32'(bus.setpointCh1), 32'd0);
    check("rst_ch2", 32'(bus.setpointCh2), 32'd0);
    check("rst_valid", 32'(bus.frameValid), 32'd0);
    check("rst_error", 32'(bus.frameError), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame
    send_good_frame(8'h12, 8'h34, 8'h05, 8'h67);
    wait_drain("drain_basic");
    check("basic_ch1", 32'(bus.setpointCh1), 32'h1234);
    check("basic_ch2", 32'(bus.setpointCh2), 32'h0567);

    // Short low glitch: no byte at all
    drive_bit(1'b0, 50);
    drive_bit(1'b1, 400);
    check("glitch_state", 32'(bus.dbg_state), 32'd0);
    check("glitch_ch1", 32'(bus.setpointCh1), 32'(exp_ch1));
    check("glitch_ch2", 32'(bus.setpointCh2), 32'(exp_ch2));

    // Bad terminator, resync on 0x0A, then good frame
    push_error();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h67, 1'b1);
    send_byte(8'h0B, 1'b1);
    wait_drain("drain_bad_term");
    send_byte(8'h0A, 1'b1);
    send_good_frame(8'h01, 8'h02, 8'h03, 8'h04);
    wait_drain("drain_after_resync");
    check("resync_ch1", 32'(bus.setpointCh1), 32'h0102);
    check("resync_ch2", 32'(bus.setpointCh2), 32'h0304);

    // Framing error with the line held low afterwards
    push_error();
    send_byte(8'h12, 1'b0);
    drive_bit(1'b0, 1000);
    wait_drain("drain_stop_err");
    check("held_low_state", 32'(bus.dbg_state), 32'd4);
    drive_bit(1'b1, 20);
    send_byte(8'h0A, 1'b1);
    send_good_frame(8'h11, 8'h22, 8'h33, 8'h44);
    wait_drain("drain_after_break");

    // Reset in the middle of byte 3
    send_byte(8'h7F, 1'b1);
    send_byte(8'h55, 1'b1);
    drive_bit(1'b0, DF);
    drive_bit(1'b1, DF);
    drive_bit(1'b0, DF / 2);
    rst = 1'b1;
    bus.uart_rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ch1 = '0;
    exp_ch2 = '0;
    check("midrst_ch1", 32'(bus.setpointCh1), 32'd0);
    check("midrst_ch2", 32'(bus.setpointCh2), 32'd0);
    check("midrst_state", 32'(bus.dbg_state), 32'd0);
    drive_bit(1'b1, 300);
    send_good_frame(8'h7F, 8'hFF, 8'h00, 8'h01);
    wait_drain("drain_after_rst");
    check("boundary_ch1", 32'(bus.setpointCh1), 32'h7FFF);
    check("boundary_ch2", 32'(bus.setpointCh2), 32'h0001);

`ifdef UART_RX_TIMEOUT_EN
    // Stalled partial frame is abandoned after the gap limit
    push_error();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    drive_bit(1'b1, 4000);
    wait_drain("drain_timeout");
    send_good_frame(8'h21, 8'h43, 8'h65, 8'h07);
    wait_drain("drain_after_timeout");
`endif

    drive_bit(1'b1, 50);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receiver for the host-to-FPGA direction of the 115200-baud 8N1 link. It samples the `uart_rx` pin and reassembles 8-bit bytes. It parses the same 5-byte frame the telemetry transmitter emits: ch1 hi, ch1 lo, ch2 hi, ch2 lo, `0x0A`. Each complete, well-formed frame produces two 15-bit words (PID setpoints or commands) with a one-cycle valid strobe.

## Interface
- `DELAY_FRAMES`, default 234: clock cycles per bit (27 MHz / 115200).
- `TIMEOUT_BITS`, default 16: inter-byte gap limit in bit periods (used only with `UART_RX_TIMEOUT_EN`).
- `clk`  in  1  system clock, 27 MHz; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `setpointCh1`  out  15  last accepted ch1 word.
- `setpointCh2`  out  15  last accepted ch2 word.
- `frameValid`  out  1  one-cycle pulse when a frame is accepted.
- `frameError`  out  1  one-cycle pulse on a framing, format or timeout error.

## Operation
- `uart_rx` passes through a 2-FF synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rxS`.
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A single 16-bit `bitCounter` and a 3-bit `bitIndex` drive it.
  - IDLE: when `rxS`==0, go to START with counter=0.
  - START: count to `DELAY_FRAMES/2`-1 (116), then sample.
    - If `rxS`==0, go to DATA with counter=0 and bitIndex=0.
    - If `rxS`==1 (glitch), go to IDLE with no error.
  - DATA: count to `DELAY_FRAMES`-1, then sample into `shift[bitIndex]`, LSB first. After bitIndex 7, go to STOP.
  - STOP: count to `DELAY_FRAMES`-1, then sample.
    - If `rxS`==1, raise the internal `byteStrobe` and go to IDLE.
    - If `rxS`==0, the byte is a framing error: pulse `frameError`, force the parser into RESYNC, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxS`==1, then go to IDLE. This prevents a held-low line or break from retriggering.
- Frame parser: `byteIndex` counts 0..4. RESYNC is a flag.
  - byteIndex 0 and 2: bit 7 must be 0. Store bits [6:0] as the hi part.
  - byteIndex 1 and 3: any value. Store as the lo part.
  - byteIndex 4: the byte must equal `0x0A`.
    - If it does, load `setpointCh1` and `setpointCh2` together from the staging registers and pulse `frameValid`.
    - Then reset byteIndex to 0.
  - Any format violation (hi bit7=1, or terminator ≠ `0x0A`) pulses `frameError`, sets RESYNC and leaves the outputs unchanged.
  - In RESYNC, bytes are discarded until a `0x0A` is received. That byte clears RESYNC and sets byteIndex=0. It does not produce `frameValid`.
- Outputs change only on an accepted frame. A partial or bad frame never updates them.
- `frameValid` and `frameError` are never asserted in the same cycle.

## Timing
- Reset values:
  - Outputs: `setpointCh1`=0, `setpointCh2`=0, `frameValid`=0, `frameError`=0.
  - Internal: FSM=IDLE, byteIndex=0, RESYNC=0, synchronizer=1.
- `rst` takes priority over every other event, including mid-byte or mid-frame. All partial data is dropped.
- Sample points fall `DELAY_FRAMES/2 + k·DELAY_FRAMES` cycles after the synchronized falling edge, for k=1..8 data bits and k=9 stop bit.
- `byteStrobe` is asserted in the stop-bit sample cycle.
- `frameValid` and the updated outputs appear 1 cycle after the `byteStrobe` of the terminator byte.
- Pin-to-synchronized latency is 2 cycles.
- The receiver is back in IDLE by mid-stop-bit, which tolerates back-to-back bytes with ≥1 stop bit at ±2% baud mismatch.

## Configuration
- `UART_RX_TIMEOUT_EN`
  - Defined: a gap counter runs while byteIndex≠0 and the FSM is IDLE. It clears on every falling start edge.
  - When the counter reaches `TIMEOUT_BITS·DELAY_FRAMES` cycles (3744 by default), byteIndex resets to 0, `frameError` pulses once and RESYNC is cleared.
  - Not defined: there is no gap counter, and a stalled partial frame waits indefinitely.

## Test plan
- Send `0x12,0x34,0x05,0x67,0x0A` at 234 cycles/bit -> `setpointCh1`=`0x1234`, `setpointCh2`=`0x0567`, and a single-cycle `frameValid` 1 cycle after the last stop sample.
- With the line idle, pulse `uart_rx` low for 50 cycles -> no byte, no `frameValid`, no `frameError`, outputs unchanged.
- Send `0x12,0x34,0x05,0x67,0x0B` -> `frameError` pulse, outputs keep their prior values. Then `0x0A` followed by `0x01,0x02,0x03,0x04,0x0A` -> outputs `0x0102`/`0x0304` and one `frameValid`.
- Drive a 0 stop bit on byte 1 and hold `uart_rx` low for 1000 cycles -> one `frameError`, no restart while low. After the line returns high, `0x0A` followed by a good frame is accepted.
- Assert `rst` for 1 cycle in the middle of byte 3 -> outputs return to 0 and the FSM is IDLE. A following full frame `0x7F,0xFF,0x00,0x01,0x0A` gives `0x7FFF`/`0x0001`.
- With `UART_RX_TIMEOUT_EN`: send 2 bytes, then idle for 4000 cycles -> `frameError` at gap cycle 3744. A subsequent complete frame is accepted with no resync byte needed.
